mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: address width of both request ports and the memory bus.
REQ-002 Parameter DATA_W, default 16: data width of all data paths.
REQ-003 Parameter WAIT_MAX, default 15: maximum number of ACCESS cycles with pready low before the transfer is aborted.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: asynchronous, active-low reset.
REQ-006 if_req  in  1: instruction-fetch read request, level, held until if_done.
REQ-007 if_addr  in  ADDR_W: fetch address.
REQ-008 if_rdata  out  DATA_W: fetch read data, valid while if_done=1.
REQ-009 if_done  out  1: one-cycle fetch completion pulse.
REQ-010 dm_req  in  1: data-memory request, level, held until dm_done.
REQ-011 dm_write  in  1: 1 = write, 0 = read.
REQ-012 dm_addr  in  ADDR_W: data address.
REQ-013 dm_wdata  in  DATA_W: write data.
REQ-014 dm_rdata  out  DATA_W: data read result, valid while dm_done=1.
REQ-015 dm_done  out  1: one-cycle data completion pulse.
REQ-016 err  out  1: one-cycle pulse coincident with the done pulse of an aborted transfer.
REQ-017 stall  out  1: pipeline hold request.
REQ-018 paddr, pwrite, psel, penable, pwdata  out  ADDR_W/1/1/1/DATA_W: memory bus master outputs.
REQ-019 prdata, pready  in  DATA_W/1: memory read data and transfer-ready.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-021 In IDLE with at least one eligible request, the FSM SHALL latch the winner's address, write flag and write data, record the winner as last_grant, and move to SETUP on the next edge.
REQ-022 A requester SHALL be eligible only if its req=1 and its done output is 0 in that cycle.
REQ-023 Arbitration: a single eligible request wins; with two eligible requests, the requester not equal to last_grant wins (round-robin).
REQ-024 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from the latched values; the FSM SHALL always move to ACCESS after one cycle.
REQ-025 ACCESS: psel=1, penable=1; on an edge with pready=1 the transfer completes, prdata is captured for reads, and the FSM returns to IDLE.
REQ-026 The done pulse for the granted port SHALL be registered and high in the cycle after completion, with that port's rdata held stable during the pulse.
REQ-027 For write transfers, rdata SHALL be 0.
REQ-028 Latency from request to done, with pready already high: request sampled at edge N, SETUP in cycle N+1, ACCESS in N+2, done in N+3 (3 cycles).
REQ-029 The wait counter SHALL be cleared on entering ACCESS and SHALL increment each ACCESS cycle with pready=0.
REQ-030 If the wait counter reaches WAIT_MAX while pready=0, the transfer SHALL abort: return to IDLE, done and err pulse next cycle, rdata=0, and no memory write is considered performed.
REQ-031 Latched values SHALL not change after grant; input changes mid-transfer are ignored.
REQ-032 Deassertion of req mid-transfer SHALL not cancel the transfer; done is still issued.
REQ-033 When idle, psel and penable SHALL be 0, while paddr, pwrite and pwdata hold their last values.
REQ-034 stall = (if_req & ~if_done) | (dm_req & ~dm_done), combinational.
REQ-035 At most one done pulse SHALL be high in any cycle.

Reset
REQ-036 While rst=0 (asynchronous), the FSM SHALL go to IDLE, all outputs SHALL be 0, the wait counter SHALL be 0, and last_grant SHALL be fetch, so data wins the first tie.
REQ-037 Reset asserted during SETUP or ACCESS SHALL abandon the transfer with no done or err pulse; after release, pending requests are re-arbitrated from IDLE.

Verification
REQ-038 Reset then dm_req=1, dm_write=0, dm_addr=0x0005, pready=1, prdata=0xBEEF -> psel=1/penable=0 in cycle 1, penable=1 in cycle 2, dm_done=1 and dm_rdata=0xBEEF in cycle 3.
REQ-039 if_req and dm_req both asserted continuously from reset -> grant order dm, if, dm, if; each done is single-cycle; stall=1 until both requests drop.
REQ-040 dm write of 0x1234 to 0x0010 with pready low for 3 ACCESS cycles -> pwdata=0x1234 and paddr=0x0010 stable throughout; dm_done 1 cycle after pready rises; dm_rdata=0.
REQ-041 WAIT_MAX=4, if_req with pready held 0 -> abort after 4 ACCESS cycles; if_done=1, err=1, if_rdata=0; psel=0 in the next cycle.
REQ-042 rst driven low during ACCESS -> psel, penable, done and stall are 0 immediately without waiting for a clock edge; after release with dm_req still high, a new SETUP follows.
REQ-043 dm_addr changed to 0x0020 during SETUP of a transfer granted at 0x0008 -> paddr stays 0x0008 until completion.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Fetch/data request ports plus memory-bus master signals of mem_arbiter
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    // data-memory requester
    logic              dm_req;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              err;
    logic              stall;

    // memory bus
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    // the arbiter side
    modport master (
        input  if_req, if_addr,
        input  dm_req, dm_write, dm_addr, dm_wdata,
        input  prdata, pready,
        output if_rdata, if_done, dm_rdata, dm_done, err, stall,
        output paddr, pwrite, psel, penable, pwdata
    );

    // requesters and memory
    modport slave (
        output if_req, if_addr,
        output dm_req, dm_write, dm_addr, dm_wdata,
        output prdata, pready,
        input  if_rdata, if_done, dm_rdata, dm_done, err, stall,
        input  paddr, pwrite, psel, penable, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin fetch/data arbiter driving a single two-phase memory bus
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  wire           clk,
    input  wire           rst_n,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    // The counter never has to hold WAIT_MAX itself: the abort fires on the
    // cycle that would have taken it there.
    localparam int                c_WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_MAX - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_gnt_dm;
    logic                r_last_dm;
    logic [c_WAIT_W-1:0] r_wait;

    logic                r_if_done;
    logic                r_dm_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_if_elig;
    logic                w_dm_elig;
    logic                w_any_elig;
    logic                w_pick_dm;
    logic                w_grant;
    logic                w_wait_hit;
    logic                w_finish;
    logic [DATA_W-1:0]   w_rdata_cap;
    logic                w_psel;
    logic                w_penable;

    // A requester whose done pulse is showing is still holding req; it must
    // not be granted again off that stale level.
    assign w_if_elig   = bus.if_req & ~r_if_done;
    assign w_dm_elig   = bus.dm_req & ~r_dm_done;
    assign w_any_elig  = w_if_elig | w_dm_elig;
    assign w_pick_dm   = w_dm_elig & (~w_if_elig | ~r_last_dm);
    assign w_grant     = (r_state == c_IDLE) & w_any_elig;

    assign w_wait_hit  = (r_wait == c_WAIT_LAST);
    assign w_finish    = (r_state == c_ACCESS) & (bus.pready | w_wait_hit);
    assign w_rdata_cap = (bus.pready & ~r_write) ? bus.prdata : '0;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_any_elig) w_state_nxt = c_SETUP;
            c_SETUP:  w_state_nxt = c_ACCESS;
            c_ACCESS: if (bus.pready || w_wait_hit) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: bus phase outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        case (r_state)
            c_SETUP:  w_psel = 1'b1;
            c_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant latch, wait counter and completion registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_gnt_dm   <= 1'b0;
            r_last_dm  <= 1'b0;
            r_wait     <= '0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_err     <= 1'b0;

            if (w_grant) begin
                r_gnt_dm  <= w_pick_dm;
                r_last_dm <= w_pick_dm;
                r_addr    <= w_pick_dm ? bus.dm_addr  : bus.if_addr;
                r_write   <= w_pick_dm & bus.dm_write;
                r_wdata   <= w_pick_dm ? bus.dm_wdata : '0;
            end

            if (r_state == c_SETUP) begin
                r_wait <= '0;
            end else if ((r_state == c_ACCESS) && !bus.pready && !w_wait_hit) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end

            // An abort reports like a completion, with err set and zero data.
            if (w_finish) begin
                r_err <= ~bus.pready;
                if (r_gnt_dm) begin
                    r_dm_done  <= 1'b1;
                    r_dm_rdata <= w_rdata_cap;
                end else begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= w_rdata_cap;
                end
            end
        end
    end

    assign bus.psel     = w_psel;
    assign bus.penable  = w_penable;
    assign bus.paddr    = r_addr;
    assign bus.pwrite   = r_write;
    assign bus.pwdata   = r_wdata;

    assign bus.if_done  = r_if_done;
    assign bus.if_rdata = r_if_rdata;
    assign bus.dm_done  = r_dm_done;
    assign bus.dm_rdata = r_dm_rdata;
    assign bus.err      = r_err;

    // Gated by reset so the pipeline is released the moment reset is applied.
    assign bus.stall    = rst_n & ((bus.if_req & ~r_if_done) | (bus.dm_req & ~r_dm_done));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and randomized checks of mem_arbiter against a transaction model
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int WAIT_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: a granted transfer is "age" cycles old;
    // age 1 is the address phase, age k+1 is the k-th data-phase cycle.
    bit          m_busy;
    int          m_age;
    bit          m_gnt_dm;
    bit          m_last_dm;
    bit          m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    bit          m_if_done;
    bit          m_dm_done;
    bit          m_err;
    logic [15:0] m_if_rdata;
    logic [15:0] m_dm_rdata;

    task automatic model_reset();
        m_busy     = 0;
        m_age      = 0;
        m_gnt_dm   = 0;
        m_last_dm  = 0;
        m_write    = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_if_done  = 0;
        m_dm_done  = 0;
        m_err      = 0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
    endtask

    task automatic model_step();
        bit          if_el;
        bit          dm_el;
        bit          pick;
        bit          n_if  = 0;
        bit          n_dm  = 0;
        bit          n_err = 0;
        logic [15:0] rd;
        if (!m_busy) begin
            if_el = bus.if_req && !m_if_done;
            dm_el = bus.dm_req && !m_dm_done;
            if (if_el || dm_el) begin
                pick      = dm_el && (!if_el || !m_last_dm);
                m_gnt_dm  = pick;
                m_last_dm = pick;
                m_addr    = pick ? bus.dm_addr : bus.if_addr;
                m_write   = pick && bus.dm_write;
                m_wdata   = bus.dm_wdata;
                m_busy    = 1;
                m_age     = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (bus.pready || (m_age - 1) == WAIT_MAX) begin
            rd    = (bus.pready && !m_write) ? bus.prdata : 16'h0000;
            n_err = !bus.pready;
            if (m_gnt_dm) begin
                n_dm       = 1;
                m_dm_rdata = rd;
            end else begin
                n_if       = 1;
                m_if_rdata = rd;
            end
            m_busy = 0;
        end else begin
            m_age = m_age + 1;
        end
        m_if_done = n_if;
        m_dm_done = n_dm;
        m_err     = n_err;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("psel",    32'(bus.psel),    32'(m_busy));
        check("penable", 32'(bus.penable), 32'(m_busy && m_age >= 2));
        check("paddr",   32'(bus.paddr),   32'(m_addr));
        check("pwrite",  32'(bus.pwrite),  32'(m_write));
        if (m_busy && m_write) check("pwdata", 32'(bus.pwdata), 32'(m_wdata));
        check("if_done", 32'(bus.if_done), 32'(m_if_done));
        check("dm_done", 32'(bus.dm_done), 32'(m_dm_done));
        check("err",     32'(bus.err),     32'(m_err));
        if (m_if_done) check("if_rdata", 32'(bus.if_rdata), 32'(m_if_rdata));
        if (m_dm_done) check("dm_rdata", 32'(bus.dm_rdata), 32'(m_dm_rdata));
        check("stall", 32'(bus.stall),
              32'(rst_n && ((bus.if_req && !m_if_done) || (bus.dm_req && !m_dm_done))));
        check("one_done", 32'(bus.if_done & bus.dm_done), 32'd0);
    endtask

    // One clock: advance the model on the inputs present at the edge, then compare.
    task automatic cycle();
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_gap(input int n);
        bus.if_req = 0;
        bus.dm_req = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string order;
        int    done_at [4];
        int    n_done;
        int    waited;
        bit    got;

        bus.if_req   = 1;
        bus.if_addr  = 16'h0100;
        bus.dm_req   = 1;
        bus.dm_write = 0;
        bus.dm_addr  = 16'h0200;
        bus.dm_wdata = 16'h0000;
        bus.prdata   = 16'hA5A5;
        bus.pready   = 1;
        model_reset();

        // Reset with both requesters already asserting
        cycle();
        cycle();
        check("rst_psel",  32'(bus.psel),  32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);

        // Both requesting continuously: dm first, then strict alternation
        rst_n  = 1;
        order  = "";
        n_done = 0;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            if (bus.dm_done || bus.if_done) begin
                if (n_done < 4) done_at[n_done] = c;
                n_done++;
                order = {order, bus.dm_done ? "D" : "I"};
            end
        end
        check("rr_ndone",  32'(n_done), 32'd4);
        check("rr_order",  (order == "DIDI") ? 32'd1 : 32'd0, 32'd1);
        check("rr_first",  32'(done_at[0]), 32'd3);
        check("rr_second", 32'(done_at[1]), 32'd6);
        idle_gap(2);

        // Single data read with the memory ready
        bus.dm_req   = 1;
        bus.dm_write = 0;
        bus.dm_addr  = 16'h0005;
        bus.prdata   = 16'hBEEF;
        bus.pready   = 1;
        cycle();
        check("rd_c1_psel",    32'(bus.psel),    32'd1);
        check("rd_c1_penable", 32'(bus.penable), 32'd0);
        cycle();
        check("rd_c2_penable", 32'(bus.penable), 32'd1);
        cycle();
        check("rd_c3_done",  32'(bus.dm_done),  32'd1);
        check("rd_c3_rdata", 32'(bus.dm_rdata), 32'h0000BEEF);
        idle_gap(2);

        // Write with three wait cycles
        bus.dm_req   = 1;
        bus.dm_write = 1;
        bus.dm_addr  = 16'h0010;
        bus.dm_wdata = 16'h1234;
        bus.pready   = 0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("wr_paddr",   32'(bus.paddr),   32'h00000010);
            check("wr_pwdata",  32'(bus.pwdata),  32'h00001234);
            check("wr_penable", 32'(bus.penable), 32'd1);
        end
        bus.pready = 1;
        cycle();
        check("wr_done",  32'(bus.dm_done),  32'd1);
        check("wr_rdata", 32'(bus.dm_rdata), 32'd0);
        check("wr_err",   32'(bus.err),      32'd0);
        bus.dm_write = 0;
        idle_gap(2);

        // Fetch against a memory that never becomes ready
        bus.if_req  = 1;
        bus.if_addr = 16'h0040;
        bus.prdata  = 16'h7777;
        bus.pready  = 0;
        waited = 0;
        got    = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            waited++;
            if (bus.if_done) got = 1;
        end
        check("abort_latency", 32'(waited),       32'd6);
        check("abort_err",     32'(bus.err),      32'd1);
        check("abort_rdata",   32'(bus.if_rdata), 32'd0);
        bus.if_req = 0;
        cycle();
        check("abort_psel_after", 32'(bus.psel), 32'd0);
        idle_gap(1);

        // Address change during the address phase is ignored
        bus.dm_req  = 1;
        bus.dm_addr = 16'h0008;
        bus.prdata  = 16'h5150;
        bus.pready  = 1;
        cycle();
        bus.dm_addr = 16'h0020;
        cycle();
        check("latch_paddr_acc", 32'(bus.paddr), 32'h00000008);
        cycle();
        check("latch_paddr_done", 32'(bus.paddr), 32'h00000008);
        check("latch_done",       32'(bus.dm_done), 32'd1);
        idle_gap(2);

        // Asynchronous reset in the middle of a data phase
        bus.dm_req  = 1;
        bus.dm_addr = 16'h0030;
        bus.pready  = 0;
        cycle();
        cycle();
        #2;
        rst_n = 0;
        #1;
        check("arst_psel",    32'(bus.psel),    32'd0);
        check("arst_penable", 32'(bus.penable), 32'd0);
        check("arst_dm_done", 32'(bus.dm_done), 32'd0);
        check("arst_stall",   32'(bus.stall),   32'd0);
        model_reset();
        cycle();
        cycle();
        rst_n      = 1;
        bus.pready = 1;
        cycle();
        check("arst_resetup_psel",    32'(bus.psel),    32'd1);
        check("arst_resetup_penable", 32'(bus.penable), 32'd0);
        cycle();
        cycle();
        idle_gap(2);

        // Randomized traffic: requesters and memory driven from $urandom
        for (int c = 0; c < 600; c++) begin
            bus.pready = ($urandom_range(0, 9) < 4);
            bus.prdata = 16'($urandom);
            cycle();
            if (bus.if_req) begin
                if (m_if_done) begin
                    if ($urandom_range(0, 3) != 0) bus.if_req = 0;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.if_req = 0;
                end
                if ($urandom_range(0, 3) == 0) bus.if_addr = 16'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                bus.if_req  = 1;
                bus.if_addr = 16'($urandom);
            end
            if (bus.dm_req) begin
                if (m_dm_done) begin
                    if ($urandom_range(0, 3) != 0) bus.dm_req = 0;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.dm_req = 0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    bus.dm_addr  = 16'($urandom);
                    bus.dm_wdata = 16'($urandom);
                    bus.dm_write = 1'($urandom);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.dm_req   = 1;
                bus.dm_addr  = 16'($urandom);
                bus.dm_wdata = 16'($urandom);
                bus.dm_write = 1'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
